vram_arbiter: RTL and testbench

- Sequences and shares one single-port 2048x8 video/bullet RAM (ram2114-class: write on clk edge; address registered; read data on q one cycle after the address edge) between two requesters.
- Requesters: video scanout fetch and the CPU bus.
- After reset, first runs a hardware clear sweep of the whole RAM, then arbitrates one access per cycle with video priority and a CPU starvation guard.
- Sits between the CPU/video address decode and the RAM instance in the tank sim top level.

---
 rtl/vram_arbiter_pkg.sv | 31 +++
 rtl/vram_clear_seq.sv | 30 +++
 rtl/vram_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and defaults for the video/CPU VRAM arbiter and the RAM it fronts.
package vram_arbiter_pkg;

  localparam int VRAM_AW  = 11;
  localparam int VRAM_DW  = 8;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2
  } owner_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Saturating increment used by the CPU starvation guard.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] val,
                                                  input logic [STARVE_W-1:0] lim);
    logic [STARVE_W-1:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/vram_clear_seq.sv
// Post-reset clear sweep: walks every RAM address once and flags the final one.
module vram_clear_seq
  import vram_arbiter_pkg::*;
#(
  parameter int AW = VRAM_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic [AW-1:0] addr,
  output logic          done
);

  logic [AW-1:0] cnt_r;

  // Sweep address counter; wraps back to zero after the last location.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {AW{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign addr = cnt_r;
  assign done = en && (cnt_r == {AW{1'b1}});

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM sequencer: clear sweep after reset, then one access per cycle
// shared between video scanout (priority) and the CPU (with a starvation guard).
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int             AW           = VRAM_AW,
  parameter int             DW           = VRAM_DW,
  parameter logic [DW-1:0]  CLEAR_VAL    = 8'h00,
  parameter int             CPU_WAIT_MAX = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q,
  output logic          clearing
);

  localparam logic [STARVE_W-1:0] WAIT_LIM = STARVE_W'(CPU_WAIT_MAX);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [STARVE_W-1:0]  starve_r;
  logic [AW-1:0]        sweep_addr_s;
  logic                 sweep_done_s;
  logic                 vid_gnt_s;
  logic                 cpu_gnt_s;
  owner_t               owner_s;
  owner_t               tag1_r;
  owner_t               tag2_r;
  logic [AW-1:0]        ram_addr_r;
  logic [DW-1:0]        ram_data_r;
  logic                 ram_we_r;
  logic [DW-1:0]        vid_data_r;
  logic                 vid_valid_r;
  logic [DW-1:0]        cpu_rdata_r;
  logic                 cpu_rvalid_r;

  vram_clear_seq #(
    .AW (AW)
  ) u_clear_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_r == CLEAR),
    .addr    (sweep_addr_s),
    .done    (sweep_done_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: leave CLEAR once the last location has been issued.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CLEAR:   state_nxt_s = sweep_done_s ? RUN : CLEAR;
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = CLEAR;
    endcase
  end

  // Grant decode: a starved CPU beats video, otherwise video wins.
  always_comb begin
    vid_gnt_s = 1'b0;
    cpu_gnt_s = 1'b0;
    owner_s   = NONE;
    if (state_r == RUN) begin
      if (cpu_req && (starve_r == WAIT_LIM)) begin
        cpu_gnt_s = 1'b1;
        owner_s   = CPU;
      end else if (vid_req) begin
        vid_gnt_s = 1'b1;
        owner_s   = VID;
      end else if (cpu_req) begin
        cpu_gnt_s = 1'b1;
        owner_s   = CPU;
      end else begin
        owner_s   = NONE;
      end
    end else begin
      owner_s = NONE;
    end
  end

  // Starvation counter only runs while arbitrating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (state_r != RUN) begin
      starve_r <= starve_r;
    end else if (cpu_gnt_s) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (cpu_req) begin
      starve_r <= sat_inc(starve_r, WAIT_LIM);
    end else begin
      starve_r <= starve_r;
    end
  end

  // RAM command register; address and data hold on idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_r <= {AW{1'b0}};
      ram_data_r <= {DW{1'b0}};
      ram_we_r   <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          ram_addr_r <= sweep_addr_s;
          ram_data_r <= CLEAR_VAL;
          ram_we_r   <= 1'b1;
        end
        RUN: begin
          if (vid_gnt_s) begin
            ram_addr_r <= vid_addr;
            ram_we_r   <= 1'b0;
          end else if (cpu_gnt_s) begin
            ram_addr_r <= cpu_addr;
            ram_data_r <= cpu_wdata;
            ram_we_r   <= cpu_we;
          end else begin
            ram_we_r   <= 1'b0;
          end
        end
        default: begin
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  // Owner tag follows each access through the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag1_r <= NONE;
      tag2_r <= NONE;
    end else begin
      tag1_r <= owner_s;
      tag2_r <= tag1_r;
    end
  end

  // Return stage: steer ram_q to whichever requester owns the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_data_r   <= {DW{1'b0}};
      vid_valid_r  <= 1'b0;
      cpu_rdata_r  <= {DW{1'b0}};
      cpu_rvalid_r <= 1'b0;
    end else begin
      vid_valid_r  <= (tag2_r == VID);
      cpu_rvalid_r <= (tag2_r == CPU);
      if (tag2_r == VID) begin
        vid_data_r <= ram_q;
      end else begin
        vid_data_r <= vid_data_r;
      end
      if (tag2_r == CPU) begin
        cpu_rdata_r <= ram_q;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
    end
  end

  assign vid_gnt    = vid_gnt_s;
  assign cpu_gnt    = cpu_gnt_s;
  assign ram_addr   = ram_addr_r;
  assign ram_data   = ram_data_r;
  assign ram_we     = ram_we_r;
  assign vid_data   = vid_data_r;
  assign vid_valid  = vid_valid_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign cpu_rvalid = cpu_rvalid_r;
  assign clearing   = (state_r == CLEAR);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 2048x8 write-through RAM.
module tb_vram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic          clearing;

  logic          preload;
  logic [DW-1:0] mem [0:2047];
  int            checks = 0;
  int            errors = 0;
  int            bad_a;
  int            bad_b;

  always #5 clk = ~clk;

  vram_arbiter #(
    .AW (AW), .DW (DW), .CLEAR_VAL (8'h00), .CPU_WAIT_MAX (3)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .vid_req (vid_req), .vid_addr (vid_addr), .vid_gnt (vid_gnt),
    .vid_data (vid_data), .vid_valid (vid_valid),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr),
    .cpu_wdata (cpu_wdata), .cpu_gnt (cpu_gnt), .cpu_rdata (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ram_addr (ram_addr), .ram_data (ram_data), .ram_we (ram_we),
    .ram_q (ram_q), .clearing (clearing)
  );

  // RAM model: preloaded with FF so the clear sweep is observable; write-through read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'hFF;
      ram_q <= 8'hFF;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= ram_we ? ram_data : mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs the full 2048-cycle sweep, optionally raising a CPU read of 0x7FF midway.
  task automatic sweep(input logic raise_cpu, output int bad_wr, output int bad_quiet);
    bad_wr = 0;
    bad_quiet = 0;
    for (int i = 0; i < 2048; i++) begin
      if (raise_cpu && i == 1000) begin
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 11'h7FF;
      end
      step();
      if (ram_we !== 1'b1 || ram_addr !== i[10:0] || ram_data !== 8'h00) bad_wr++;
      if (i < 2047) begin
        if (clearing !== 1'b1 || cpu_gnt !== 1'b0 || vid_gnt !== 1'b0 ||
            cpu_rvalid !== 1'b0 || vid_valid !== 1'b0) bad_quiet++;
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    preload   = 1'b1;
    vid_req   = 1'b0;
    vid_addr  = 11'h000;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 11'h000;
    cpu_wdata = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_data", ram_data, 32'h0);
    chk("rst_ram_we", ram_we, 32'h0);
    chk("rst_clearing", clearing, 32'h1);
    chk("rst_vid_valid", vid_valid, 32'h0);
    chk("rst_cpu_rvalid", cpu_rvalid, 32'h0);
    chk("rst_vid_data", vid_data, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_gnts", {vid_gnt, cpu_gnt}, 32'h0);

    preload = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Clear sweep with a CPU read pending from mid-sweep.
    sweep(1'b1, bad_a, bad_b);
    chk("sweep_writes", bad_a, 32'h0);
    chk("sweep_quiet", bad_b, 32'h0);
    chk("sweep_end_clearing", clearing, 32'h0);
    chk("first_run_cpu_gnt", cpu_gnt, 32'h1);
    step();
    cpu_req = 1'b0;
    chk("rd7ff_ram_addr", ram_addr, 32'h7FF);
    chk("rd7ff_ram_we", ram_we, 32'h0);
    step();
    chk("rd7ff_early", cpu_rvalid, 32'h0);
    step();
    chk("rd7ff_rvalid", cpu_rvalid, 32'h1);
    chk("rd7ff_rdata", cpu_rdata, 32'h00);
    step();
    chk("rd7ff_strobe_end", cpu_rvalid, 32'h0);

    // CPU write 0x123=A5 then back-to-back read.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 8'hA5;
    #1;
    chk("wr_cpu_gnt", cpu_gnt, 32'h1);
    chk("wr_vid_gnt", vid_gnt, 32'h0);
    step();
    chk("wr_ram_we", ram_we, 32'h1);
    chk("wr_ram_addr", ram_addr, 32'h123);
    chk("wr_ram_data", ram_data, 32'hA5);
    cpu_we = 1'b0; cpu_wdata = 8'h00;
    #1;
    chk("rd_cpu_gnt", cpu_gnt, 32'h1);
    step();
    cpu_req = 1'b0;
    chk("rd_ram_we", ram_we, 32'h0);
    chk("wr_rvalid_early", cpu_rvalid, 32'h0);
    step();
    chk("wr_done_rvalid", cpu_rvalid, 32'h1);
    chk("wr_done_rdata", cpu_rdata, 32'hA5);
    step();
    chk("rd_rvalid", cpu_rvalid, 32'h1);
    chk("rd_rdata", cpu_rdata, 32'hA5);
    step();
    chk("rd_strobe_end", cpu_rvalid, 32'h0);

    // Video held continuously; CPU forced in on the fourth cycle.
    vid_req = 1'b1; vid_addr = 11'h123;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("starve_vid_gnt", vid_gnt, 32'h1);
      chk("starve_cpu_wait", cpu_gnt, 32'h0);
      step();
    end
    #1;
    chk("starve_cpu_forced", cpu_gnt, 32'h1);
    chk("starve_vid_lost", vid_gnt, 32'h0);
    step();
    cpu_req = 1'b0;
    #1;
    chk("starve_vid_resume", vid_gnt, 32'h1);
    chk("starve_cpu_off", cpu_gnt, 32'h0);
    step();
    step();
    chk("starve_cpu_rvalid", cpu_rvalid, 32'h1);
    chk("starve_cpu_rdata", cpu_rdata, 32'hA5);
    chk("starve_no_vid_slot", vid_valid, 32'h0);
    vid_req = 1'b0;
    step();
    chk("starve_vid_valid", vid_valid, 32'h1);
    chk("starve_vid_data", vid_data, 32'hA5);
    step();
    step();

    // CPU writes addr-low-byte to 0x000..0x00F, then a 16-deep video burst.
    bad_a = 0;
    for (int k = 0; k < 16; k++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(k); cpu_wdata = DW'(k);
      #1;
      if (cpu_gnt !== 1'b1) bad_a++;
      step();
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("burst_wr_gnts", bad_a, 32'h0);
    for (int j = 0; j < 18; j++) begin
      if (j < 16) begin
        vid_req = 1'b1; vid_addr = AW'(j);
      end else begin
        vid_req = 1'b0;
      end
      step();
      if (j < 2) begin
        chk("burst_vid_idle", vid_valid, 32'h0);
      end else begin
        chk("burst_vid_valid", vid_valid, 32'h1);
        chk("burst_vid_data", vid_data, 32'(j - 2));
      end
    end
    step();
    chk("burst_vid_end", vid_valid, 32'h0);

    // Reset pulse while a CPU read of 0x005 is in flight.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005;
    #1;
    chk("rst_rd_gnt", cpu_gnt, 32'h1);
    step();
    cpu_req = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_clearing", clearing, 32'h1);
    chk("midrst_ram_addr", ram_addr, 32'h0);
    chk("midrst_ram_we", ram_we, 32'h0);
    chk("midrst_rvalid", cpu_rvalid, 32'h0);
    step();
    chk("midrst_rvalid_held", cpu_rvalid, 32'h0);
    reset_n = 1'b1;
    sweep(1'b0, bad_a, bad_b);
    chk("resweep_writes", bad_a, 32'h0);
    chk("resweep_quiet", bad_b, 32'h0);
    chk("resweep_clearing", clearing, 32'h0);

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005;
    #1;
    chk("post_rd_gnt", cpu_gnt, 32'h1);
    step();
    cpu_req = 1'b0;
    step();
    step();
    chk("post_rd_rvalid", cpu_rvalid, 32'h1);
    chk("post_rd_rdata", cpu_rdata, 32'h00);
    vid_req = 1'b1; vid_addr = 11'h00F;
    #1;
    chk("post_vid_gnt", vid_gnt, 32'h1);
    step();
    vid_req = 1'b0;
    step();
    step();
    chk("post_vid_valid", vid_valid, 32'h1);
    chk("post_vid_data", vid_data, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
